// File: rtl/ahci_dma_pkg.sv
// Shared types, constants and helper functions for the AHCI DMA read realigner.
package ahci_dma_pkg;

  localparam int unsigned WORD_BITS = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Ceiling log2 used for parameter-derived widths.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Beats needed to cover offs skipped words plus wcnt delivered words.
  function automatic logic [31:0] beat_count(input logic [31:0] offs,
                                             input logic [31:0] wcnt,
                                             input int unsigned words_log);
    logic [31:0] round_up;
    round_up = (32'd1 << words_log) - 32'd1;
    return (offs + wcnt + round_up) >> words_log;
  endfunction

endpackage

// File: rtl/ahci_dma_rd_realign_if.sv
// Handshake bundle between the beat source / word sink and the realigner.
// Optional abort port is present when AHCI_DMA_RD_REALIGN_ABORT_EN is defined.
interface ahci_dma_rd_realign_if
  import ahci_dma_pkg::*;
#(
  parameter int unsigned DIN_WORDS = 2,
  parameter int unsigned WCNT_BITS = 21
) ();

  localparam int unsigned OFFS_BITS = clog2(DIN_WORDS);
  localparam int unsigned BEAT_BITS = WORD_BITS * DIN_WORDS;

  logic                 start;
  logic [OFFS_BITS-1:0] offs;
  logic [WCNT_BITS-1:0] wcnt;
  logic [BEAT_BITS-1:0] din;
  logic                 din_av;
  logic                 din_re;
  logic [WORD_BITS-1:0] dout;
  logic                 dout_av;
  logic                 dout_av_many;
  logic                 dout_re;
  logic                 busy;
  logic                 done;
`ifdef AHCI_DMA_RD_REALIGN_ABORT_EN
  logic                 abort;

  modport master (output start, offs, wcnt, din, din_av, dout_re, abort,
                  input  din_re, dout, dout_av, dout_av_many, busy, done);
  modport slave  (input  start, offs, wcnt, din, din_av, dout_re, abort,
                  output din_re, dout, dout_av, dout_av_many, busy, done);
`else
  modport master (output start, offs, wcnt, din, din_av, dout_re,
                  input  din_re, dout, dout_av, dout_av_many, busy, done);
  modport slave  (input  start, offs, wcnt, din, din_av, dout_re,
                  output din_re, dout, dout_av, dout_av_many, busy, done);
`endif

endinterface

// File: rtl/ahci_dma_beat_fifo.sv
// Single-clock first-word-fall-through register FIFO holding input beats.
module ahci_dma_beat_fifo #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned DEPTH_LOG = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout,
  output logic                 full,
  output logic                 empty,
  output logic [DEPTH_LOG:0]   count
);

  localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic [DEPTH_LOG:0]   fill;

  // Pointers wrap naturally at 2^DEPTH_LOG.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG'(1);
      if (push && !pop)      fill <= fill + (DEPTH_LOG+1)'(1);
      else if (pop && !push) fill <= fill - (DEPTH_LOG+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (fill == (DEPTH_LOG+1)'(DEPTH));
  assign empty = (fill == '0);
  assign count = fill;

endmodule

// File: rtl/ahci_dma_rd_realign.sv
// Realigning beat-to-word converter: skips offs leading words, delivers exactly wcnt words.
// Optional abort input enabled by defining AHCI_DMA_RD_REALIGN_ABORT_EN.
module ahci_dma_rd_realign
  import ahci_dma_pkg::*;
#(
  parameter int unsigned DIN_WORDS = 2,
  parameter int unsigned WCNT_BITS = 21,
  parameter int unsigned DEPTH_LOG = 3,
  parameter int unsigned MANY_THR  = 8
) (
  input  logic                 mclk,
  input  logic                 mrst,
  ahci_dma_rd_realign_if.slave bus
);

  localparam int unsigned OFFS_BITS = clog2(DIN_WORDS);
  localparam int unsigned BEAT_BITS = WORD_BITS * DIN_WORDS;
  localparam int unsigned CNT_BITS  = WCNT_BITS + 1;

  state_t                              state;
  state_t                              state_nx;
  logic [OFFS_BITS-1:0]                word_idx;
  logic [WCNT_BITS-1:0]                words_left;
  logic [CNT_BITS-1:0]                 beats_left;
  logic                                many_q;
  logic                                done_q;

  logic                                full;
  logic                                empty;
  logic [DEPTH_LOG:0]                  fill;
  logic [DIN_WORDS-1:0][WORD_BITS-1:0] head;

  logic                                abort_hit;
  logic                                flush;
  logic                                din_re_c;
  logic                                dout_av_c;
  logic                                take_c;
  logic                                last_c;
  logic                                pop_c;
  logic [CNT_BITS-1:0]                 avail_c;
  logic [CNT_BITS-1:0]                 deliv_c;

`ifdef AHCI_DMA_RD_REALIGN_ABORT_EN
  assign abort_hit = (state == RUN) && bus.abort;
`else
  assign abort_hit = 1'b0;
`endif
  assign flush = mrst || abort_hit;

  always_ff @(posedge mclk) begin
    if (mrst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start && (bus.wcnt != '0)) state_nx = RUN;
      RUN:  if (abort_hit || last_c)           state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshakes depend only on registered state and the live valid/ready inputs.
  always_comb begin
    din_re_c  = 1'b0;
    dout_av_c = 1'b0;
    take_c    = 1'b0;
    last_c    = 1'b0;
    pop_c     = 1'b0;
    if (state == RUN && !abort_hit) begin
      din_re_c  = bus.din_av && (beats_left != '0) && !full;
      dout_av_c = !empty && (words_left != '0);
      take_c    = dout_av_c && bus.dout_re;
      last_c    = take_c && (words_left == WCNT_BITS'(1));
      pop_c     = take_c && ((word_idx == OFFS_BITS'(DIN_WORDS - 1)) ||
                             (words_left == WCNT_BITS'(1)));
    end
  end

  always_ff @(posedge mclk) begin
    if (flush) begin
      word_idx   <= '0;
      words_left <= '0;
      beats_left <= '0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        word_idx   <= bus.offs;
        words_left <= bus.wcnt;
        beats_left <= CNT_BITS'(beat_count(32'(bus.offs), 32'(bus.wcnt), OFFS_BITS));
      end
    end else begin
      if (din_re_c) beats_left <= beats_left - CNT_BITS'(1);
      if (take_c) begin
        words_left <= words_left - WCNT_BITS'(1);
        word_idx   <= word_idx + OFFS_BITS'(1);
      end
    end
  end

  // Deliverable words: buffered words past the read index, capped by what is still owed.
  always_comb begin
    avail_c = '0;
    if (fill != '0) avail_c = (CNT_BITS'(fill) << OFFS_BITS) - CNT_BITS'(word_idx);
    deliv_c = (CNT_BITS'(words_left) < avail_c) ? CNT_BITS'(words_left) : avail_c;
  end

  always_ff @(posedge mclk) begin
    if (mrst) begin
      many_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      many_q <= (state_nx == RUN) && (deliv_c >= CNT_BITS'(MANY_THR));
      done_q <= ((state == IDLE) && bus.start && (bus.wcnt == '0)) || last_c;
    end
  end

  ahci_dma_beat_fifo #(
    .WIDTH     (BEAT_BITS),
    .DEPTH_LOG (DEPTH_LOG)
  ) u_fifo (
    .clk   (mclk),
    .rst   (flush),
    .push  (din_re_c),
    .pop   (pop_c),
    .din   (bus.din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fill)
  );

  assign bus.din_re       = din_re_c;
  assign bus.dout_av      = dout_av_c;
  assign bus.dout         = head[word_idx];
  assign bus.dout_av_many = many_q;
  assign bus.busy         = (state == RUN);
  assign bus.done         = done_q;

endmodule
